// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with stall/flush and M/W operand forwarding feeding the ALU.
// Build option: define IDEX_SLL_EN to drive shamt from instr_E[10:6]; otherwise shamt is tied to 0.
`default_nettype none

module id_ex_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] instr_D,
  input  logic [31:0] pc_D,
  input  logic [31:0] rs_data_D,
  input  logic [31:0] rt_data_D,
  input  logic [31:0] ext_imm_D,
  input  logic [2:0]  alu_op_D,
  input  logic        srcb_imm_D,
  input  logic        reg_we_D,
  input  logic [4:0]  wa_D,
  input  logic        mem_we_D,
  input  logic        mem_to_reg_D,
  input  logic [1:0]  tnew_D,
  input  logic [4:0]  wa_M,
  input  logic        we_M,
  input  logic [1:0]  tnew_M,
  input  logic [31:0] wd_M,
  input  logic [4:0]  wa_W,
  input  logic        we_W,
  input  logic [31:0] wd_W,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic [4:0]  shamt,
  output logic [2:0]  ALUOp,
  output logic [31:0] rt_fwd_E,
  output logic [31:0] pc_E,
  output logic [31:0] instr_E,
  output logic        reg_we_E,
  output logic [4:0]  wa_E,
  output logic        mem_we_E,
  output logic        mem_to_reg_E,
  output logic [1:0]  tnew_E
);

  logic [31:0] rs_data_E;
  logic [31:0] rt_data_E;
  logic [31:0] ext_imm_E;
  logic        srcb_imm_E;
  logic [4:0]  rs_E;
  logic [4:0]  rt_E;

  // A flush loads the same bubble as reset: sll $0,$0,0 with no side effects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_E         <= RESET_PC;
      instr_E      <= 32'd0;
      rs_data_E    <= 32'd0;
      rt_data_E    <= 32'd0;
      ext_imm_E    <= 32'd0;
      srcb_imm_E   <= 1'b0;
      ALUOp        <= 3'd0;
      reg_we_E     <= 1'b0;
      wa_E         <= 5'd0;
      mem_we_E     <= 1'b0;
      mem_to_reg_E <= 1'b0;
      tnew_E       <= 2'd0;
    end else if (flush) begin
      pc_E         <= RESET_PC;
      instr_E      <= 32'd0;
      rs_data_E    <= 32'd0;
      rt_data_E    <= 32'd0;
      ext_imm_E    <= 32'd0;
      srcb_imm_E   <= 1'b0;
      ALUOp        <= 3'd0;
      reg_we_E     <= 1'b0;
      wa_E         <= 5'd0;
      mem_we_E     <= 1'b0;
      mem_to_reg_E <= 1'b0;
      tnew_E       <= 2'd0;
    end else if (en) begin
      pc_E         <= pc_D;
      instr_E      <= instr_D;
      rs_data_E    <= rs_data_D;
      rt_data_E    <= rt_data_D;
      ext_imm_E    <= ext_imm_D;
      srcb_imm_E   <= srcb_imm_D;
      ALUOp        <= alu_op_D;
      reg_we_E     <= reg_we_D;
      wa_E         <= wa_D;
      mem_we_E     <= mem_we_D;
      mem_to_reg_E <= mem_to_reg_D;
      tnew_E       <= tnew_D;
    end
  end

  assign rs_E = instr_E[25:21];
  assign rt_E = instr_E[20:16];

  // M wins over W; $0 is never forwarded, and M only when its result is ready.
  always_comb begin
    SrcA = rs_data_E;
    if (we_M && (wa_M == rs_E) && (rs_E != 5'd0) && (tnew_M == 2'd0))
      SrcA = wd_M;
    else if (we_W && (wa_W == rs_E) && (rs_E != 5'd0))
      SrcA = wd_W;
  end

  always_comb begin
    rt_fwd_E = rt_data_E;
    if (we_M && (wa_M == rt_E) && (rt_E != 5'd0) && (tnew_M == 2'd0))
      rt_fwd_E = wd_M;
    else if (we_W && (wa_W == rt_E) && (rt_E != 5'd0))
      rt_fwd_E = wd_W;
  end

  assign SrcB = srcb_imm_E ? ext_imm_E : rt_fwd_E;

`ifdef IDEX_SLL_EN
  assign shamt = instr_E[10:6];
`else
  assign shamt = 5'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a behavioural pipeline model.
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, en, flush;
  logic [31:0] instr_D, pc_D, rs_data_D, rt_data_D, ext_imm_D;
  logic [2:0]  alu_op_D;
  logic        srcb_imm_D, reg_we_D, mem_we_D, mem_to_reg_D;
  logic [4:0]  wa_D;
  logic [1:0]  tnew_D;
  logic [4:0]  wa_M, wa_W;
  logic        we_M, we_W;
  logic [1:0]  tnew_M;
  logic [31:0] wd_M, wd_W;
  logic [31:0] SrcA, SrcB, rt_fwd_E, pc_E, instr_E;
  logic [4:0]  shamt, wa_E;
  logic [2:0]  ALUOp;
  logic        reg_we_E, mem_we_E, mem_to_reg_E;
  logic [1:0]  tnew_E;

  int passes = 0;
  int total  = 0;

  // Behavioural model of the latched EX-stage instruction.
  typedef struct {
    logic [31:0] pc, instr, rs, rt, imm;
    logic        sel_imm, reg_we, mem_we, mtr;
    logic [2:0]  op;
    logic [4:0]  wa;
    logic [1:0]  tnew;
  } ex_t;
  ex_t m;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .instr_D(instr_D), .pc_D(pc_D), .rs_data_D(rs_data_D), .rt_data_D(rt_data_D),
    .ext_imm_D(ext_imm_D), .alu_op_D(alu_op_D), .srcb_imm_D(srcb_imm_D),
    .reg_we_D(reg_we_D), .wa_D(wa_D), .mem_we_D(mem_we_D), .mem_to_reg_D(mem_to_reg_D),
    .tnew_D(tnew_D), .wa_M(wa_M), .we_M(we_M), .tnew_M(tnew_M), .wd_M(wd_M),
    .wa_W(wa_W), .we_W(we_W), .wd_W(wd_W),
    .SrcA(SrcA), .SrcB(SrcB), .shamt(shamt), .ALUOp(ALUOp), .rt_fwd_E(rt_fwd_E),
    .pc_E(pc_E), .instr_E(instr_E), .reg_we_E(reg_we_E), .wa_E(wa_E),
    .mem_we_E(mem_we_E), .mem_to_reg_E(mem_to_reg_E), .tnew_E(tnew_E)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  function automatic ex_t bubble();
    ex_t b;
    b.pc = 32'h0000_3000; b.instr = 0; b.rs = 0; b.rt = 0; b.imm = 0;
    b.sel_imm = 0; b.reg_we = 0; b.mem_we = 0; b.mtr = 0; b.op = 0; b.wa = 0; b.tnew = 0;
    return b;
  endfunction

  function automatic logic [31:0] fwd_ref(input int r, input logic [31:0] latched);
    if (r == 0) return latched;
    if (we_M && int'(wa_M) == r && tnew_M == 0) return wd_M;
    if (we_W && int'(wa_W) == r) return wd_W;
    return latched;
  endfunction

  task automatic model_edge();
    if (flush) m = bubble();
    else if (en) begin
      m.pc = pc_D; m.instr = instr_D; m.rs = rs_data_D; m.rt = rt_data_D; m.imm = ext_imm_D;
      m.sel_imm = srcb_imm_D; m.reg_we = reg_we_D; m.mem_we = mem_we_D; m.mtr = mem_to_reg_D;
      m.op = alu_op_D; m.wa = wa_D; m.tnew = tnew_D;
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] a, b;
    logic [4:0]  sh;
    a = fwd_ref(int'(m.instr[25:21]), m.rs);
    b = fwd_ref(int'(m.instr[20:16]), m.rt);
`ifdef IDEX_SLL_EN
    sh = m.instr[10:6];
`else
    sh = 5'd0;
`endif
    check({tag, ".SrcA"},   SrcA, a);
    check({tag, ".rtfwd"},  rt_fwd_E, b);
    check({tag, ".SrcB"},   SrcB, m.sel_imm ? m.imm : b);
    check({tag, ".shamt"},  {27'd0, shamt}, {27'd0, sh});
    check({tag, ".ALUOp"},  {29'd0, ALUOp}, {29'd0, m.op});
    check({tag, ".pc"},     pc_E, m.pc);
    check({tag, ".instr"},  instr_E, m.instr);
    check({tag, ".ctrl"},   {24'd0, reg_we_E, wa_E, mem_we_E, mem_to_reg_E},
                            {24'd0, m.reg_we, m.wa, m.mem_we, m.mtr});
    check({tag, ".tnew"},   {30'd0, tnew_E}, {30'd0, m.tnew});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_d();
    instr_D = $urandom;
    instr_D[25:21] = 5'($urandom_range(0, 3));
    instr_D[20:16] = 5'($urandom_range(0, 3));
    pc_D = $urandom; rs_data_D = $urandom; rt_data_D = $urandom; ext_imm_D = $urandom;
    alu_op_D = 3'($urandom_range(0, 4)); srcb_imm_D = 1'($urandom);
    reg_we_D = 1'($urandom); wa_D = 5'($urandom); mem_we_D = 1'($urandom);
    mem_to_reg_D = 1'($urandom); tnew_D = 2'($urandom);
  endtask

  task automatic rand_mw();
    wa_M = 5'($urandom_range(0, 3)); we_M = 1'($urandom); tnew_M = 2'($urandom_range(0, 1));
    wd_M = $urandom;
    wa_W = 5'($urandom_range(0, 3)); we_W = 1'($urandom); wd_W = $urandom;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; flush = 1'b0;
    rand_d();
    we_M = 0; wa_M = 0; tnew_M = 0; wd_M = 0; we_W = 0; wa_W = 0; wd_W = 0;
    m = bubble();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    @(negedge clk); reset = 1'b0;

    // Load something, then assert reset mid-cycle: outputs must clear immediately.
    tick();
    #2; reset = 1'b1; m = bubble(); #1;
    check("rst.pc",    pc_E, 32'h0000_3000);
    check("rst.regwe", {31'd0, reg_we_E}, 32'd0);
    check("rst.SrcA",  SrcA, 32'd0);
    @(negedge clk); reset = 1'b0;

    // addu $3,$1,$2 with no hazard.
    instr_D = 32'h0022_1821; rs_data_D = 5; rt_data_D = 7; srcb_imm_D = 0; alu_op_D = 3'b000;
    tick();
    check("addu.SrcA", SrcA, 32'd5);
    check("addu.SrcB", SrcB, 32'd7);
    check("addu.op",   {29'd0, ALUOp}, 32'd0);
    check_all("addu");

    // M beats W when ready; W used when M not ready.
    wa_M = 1; we_M = 1; tnew_M = 0; wd_M = 9; wa_W = 1; we_W = 1; wd_W = 4; #1;
    check("fwdM.SrcA", SrcA, 32'd9);
    tnew_M = 1; #1;
    check("fwdW.SrcA", SrcA, 32'd4);

    // $0 is never forwarded.
    @(negedge clk);
    instr_D = 32'h0002_1821; rs_data_D = 0;
    wa_M = 0; we_M = 1; tnew_M = 0; wd_M = 32'hFFFF; we_W = 0;
    tick();
    check("zero.SrcA", SrcA, 32'd0);

    // Stall for 3 cycles while D inputs change, then flush during stall.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rand_d(); rand_mw();
      tick(); check_all("hold");
    end
    @(negedge clk); flush = 1'b1; rand_d();
    tick();
    check("flush.instr", instr_E, 32'd0);
    check("flush.pc",    pc_E, 32'h0000_3000);
    check_all("flush");
    @(negedge clk); flush = 1'b0; en = 1'b1;

    // ori immediate path and sll shift amount.
    instr_D = 32'h3422_00F0; ext_imm_D = 32'h0000_00F0; srcb_imm_D = 1; alu_op_D = 3'b010;
    tick();
    check("ori.SrcB", SrcB, 32'h0000_00F0);
    @(negedge clk);
    instr_D = 32'h0002_1900; srcb_imm_D = 0; alu_op_D = 3'b100;
    tick();
`ifdef IDEX_SLL_EN
    check("sll.shamt", {27'd0, shamt}, 32'd4);
`else
    check("sll.shamt", {27'd0, shamt}, 32'd0);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rand_d(); rand_mw();
      en = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      tick();
      check_all("rnd");
      rand_mw(); #1;
      check_all("rndfwd");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire
